// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-high segment
// patterns for BCD digits and the bit position of each segment.
package seg7_pkg;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD to 7-segment decoder (active-high, segments a..g).
// Non-BCD codes decode to an all-off pattern.
module seg7_dec
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] pat
);

  always_comb begin
    pat = SEG_BLANK[SEG_G:SEG_A];
    case (bcd)
      4'd0: pat = SEG_0[SEG_G:SEG_A];
      4'd1: pat = SEG_1[SEG_G:SEG_A];
      4'd2: pat = SEG_2[SEG_G:SEG_A];
      4'd3: pat = SEG_3[SEG_G:SEG_A];
      4'd4: pat = SEG_4[SEG_G:SEG_A];
      4'd5: pat = SEG_5[SEG_G:SEG_A];
      4'd6: pat = SEG_6[SEG_G:SEG_A];
      4'd7: pat = SEG_7[SEG_G:SEG_A];
      4'd8: pat = SEG_8[SEG_G:SEG_A];
      4'd9: pat = SEG_9[SEG_G:SEG_A];
      default: pat = SEG_BLANK[SEG_G:SEG_A];
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit 7-segment driver with per-slot blanking gap,
// blink, leading-zero blanking and a once-per-frame shadow latch of the inputs.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV    = 12500,
  parameter int BLANK_CYC   = 16,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit DIG_ACT_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] dp,
  input  logic [3:0] blink,
  input  logic       blink_tick,
  input  logic       lzb,
  output logic [7:0] seg,
  output logic [3:0] dig,
  output logic       frame
);

  localparam int              CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]   BLANK_LIM = CW'(BLANK_CYC);
  localparam logic [7:0]      SEG_OFF   = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [3:0]      DIG_OFF   = DIG_ACT_LOW ? 4'hF : 4'h0;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    slot_q, slot_d;
  logic          phase_q, phase_d;
  logic [3:0]    sh_dig_q [4];
  logic [3:0]    sh_dig_d [4];
  logic [3:0]    sh_dp_q, sh_dp_d;
  logic [3:0]    sh_blink_q, sh_blink_d;
  logic          sh_lzb_q, sh_lzb_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    dig_q, dig_d;

  logic          cnt_last;
  logic          latch;
  logic [3:0]    cur_bcd;
  logic [6:0]    cur_pat;
  logic [7:0]    seg_raw;
  logic [3:0]    dig_hot;

  seg7_dec u_dec (
    .bcd (cur_bcd),
    .pat (cur_pat)
  );

  always_comb begin
    cnt_last   = (cnt_q == CNT_LAST);
    latch      = cnt_last && (slot_q == 2'd3);
    cnt_d      = cnt_last ? '0 : cnt_q + 1'b1;
    slot_d     = cnt_last ? slot_q + 2'd1 : slot_q;
    phase_d    = phase_q ^ blink_tick;

    sh_dig_d   = sh_dig_q;
    sh_dp_d    = sh_dp_q;
    sh_blink_d = sh_blink_q;
    sh_lzb_d   = sh_lzb_q;
    if (latch) begin
      sh_dig_d[0] = d0;
      sh_dig_d[1] = d1;
      sh_dig_d[2] = d2;
      sh_dig_d[3] = d3;
      sh_dp_d     = dp;
      sh_blink_d  = blink;
      sh_lzb_d    = lzb;
    end

    // Output path works from the current (slot, cnt); the register adds the one-cycle lag.
    cur_bcd = sh_dig_q[slot_q];
    seg_raw = {sh_dp_q[slot_q], cur_pat};
    if (sh_lzb_q && (slot_q == 2'd3) && (sh_dig_q[3] == 4'd0)) begin
      seg_raw[SEG_G:SEG_A] = SEG_BLANK[SEG_G:SEG_A];
    end
    if (phase_q && sh_blink_q[slot_q]) begin
      seg_raw = SEG_BLANK;
    end
    dig_hot = 4'b0001 << slot_q;

    if (cnt_q < BLANK_LIM) begin
      seg_d = SEG_OFF;
      dig_d = DIG_OFF;
    end else begin
      seg_d = SEG_ACT_LOW ? ~seg_raw : seg_raw;
      dig_d = DIG_ACT_LOW ? ~dig_hot : dig_hot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      slot_q     <= 2'd0;
      phase_q    <= 1'b0;
      sh_dig_q   <= '{default: 4'd0};
      sh_dp_q    <= 4'd0;
      sh_blink_q <= 4'd0;
      sh_lzb_q   <= 1'b0;
      seg_q      <= SEG_OFF;
      dig_q      <= DIG_OFF;
    end else begin
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      phase_q    <= phase_d;
      sh_dig_q   <= sh_dig_d;
      sh_dp_q    <= sh_dp_d;
      sh_blink_q <= sh_blink_d;
      sh_lzb_q   <= sh_lzb_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  assign seg   = seg_q;
  assign dig   = dig_q;
  assign frame = latch;

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Time-multiplexed 4-digit 7-segment display driver.
- Sits directly downstream of the seconds/minutes BCD counter chain and consumes its digit outputs:
  - d0: seconds ones
  - d1: seconds tens
  - d2: minutes ones
  - d3: minutes tens
- Scans one digit per slot, with a blanking gap between digits to prevent ghosting.
- Adds blink, leading-zero blanking and decimal-point control, and latches digits once per frame so a frame never shows mixed values.

Parameters:
- SCAN_DIV, 12500: clock cycles per digit slot. Must be ≥ BLANK_CYC+2.
- BLANK_CYC, 16: cycles at the start of each slot during which all digits and segments are inactive.
- SEG_ACT_LOW, 1: 1 means segment outputs are active-low.
- DIG_ACT_LOW, 1: 1 means digit-select outputs are active-low.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- d0  in  4  BCD digit 0 (rightmost, seconds ones).
- d1  in  4  BCD digit 1 (seconds tens).
- d2  in  4  BCD digit 2 (minutes ones).
- d3  in  4  BCD digit 3 (leftmost, minutes tens).
- dp  in  4  decimal point request per digit; bit i maps to digit i.
- blink  in  4  blink enable per digit.
- blink_tick  in  1  single-cycle pulse (the 1 Hz enable) that toggles the blink phase.
- lzb  in  1  leading-zero blank enable for digit 3.
- seg  out  8  segment drive {dp,g,f,e,d,c,b,a}.
- dig  out  4  digit select, one-hot when active; bit i maps to digit i.
- frame  out  1  one-cycle pulse when a new frame's digits are latched.

Behaviour:
- Reset (async, rst=1), all state forced immediately:
  - cnt=0, slot=0, phase=0, shadow digits/dp/blink/lzb=0, frame=0.
  - seg and dig at their inactive levels: 8'hFF and 4'hF with the default parameters.
- Slot counter:
  - cnt counts 0..SCAN_DIV-1 every clock and wraps to 0.
  - On the wrap, slot advances 0→1→2→3→0, two-bit wrap-around.
- Frame latch:
  - When cnt==SCAN_DIV-1 and slot==3, the shadow registers capture d0..d3, dp, blink and lzb.
  - frame pulses 1 in that same cycle.
  - Slot 0 of the next frame uses the new values.
  - Input changes mid-frame are invisible until the next frame; latency is up to one frame plus one cycle.
- Output register:
  - seg and dig are registered and reflect the (slot, cnt) of the previous cycle.
  - This fixed one-cycle lag is required.
- Blanking:
  - If cnt < BLANK_CYC, dig is all inactive and seg is all inactive.
  - Otherwise dig drives only bit slot active.
- Segment value for active slot s:
  - Decoded pattern of shadow digit s.
  - BCD 0–9 use standard patterns, active-high: 3F,06,5B,4F,66,6D,7D,07,7F,6F.
  - Codes A–F decode to blank (00); no error flag.
  - Bit 7 = shadow dp[s].
- Leading-zero blanking: if shadow lzb=1, s==3 and shadow d3==0, segments a–g are off. The dp bit is still honoured.
- Blink:
  - phase toggles on every blink_tick.
  - When phase==1 and shadow blink[s]==1, all 8 segment bits are off.
  - dig is still driven normally.
  - blink_tick during reset is ignored. Ticks are sampled every cycle regardless of slot.
- Polarity: the final seg is inverted if SEG_ACT_LOW, and dig is inverted if DIG_ACT_LOW.
- Simultaneous events: a frame latch and a blink_tick in the same cycle both take effect, so the new phase applies from slot 0.
- Reset asserted mid-slot: outputs go inactive asynchronously. After release, the scan restarts at slot 0, cnt 0, displaying zeros.

Decomposition:
- Shared package: seg7_pkg holds
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK (8'h00);
  - bit-position constants for a–g and dp.
- One sub-module: seg7_dec, a combinational 4-bit BCD to 7-bit pattern decoder using the package constants. It is instanced once on the muxed shadow digit.

Test Plan (SCAN_DIV=8, BLANK_CYC=2, active-low defaults):
- Reset: assert rst mid-scan → seg=8'hFF and dig=4'hF in the same cycle. After release, frame first pulses at cycle 31 (32nd clock, counting from 0).
- d3..d0=1,2,3,4, dp=0, blink=0, lzb=0, one frame elapsed:
  - Slot 0: cycles 0–1 of the slot read dig=F, seg=FF; cycles 2–7 read dig=4'b1110, seg=8'h99.
  - Slot 1: seg=8'hB0, dig=4'b1101.
- Mid-frame change of d0 from 4 to 9 during slot 2 → slot 3 and the remainder of the frame are unchanged. The next slot 0 shows seg=8'h90.
- lzb=1, d3=0, dp=4'b1000 → slot 3 shows seg=8'h7F (only dp lit). With lzb=0 it shows 8'h40.
- blink=4'b0011 with one blink_tick → slots 0/1 show seg=FF while dig still cycles. A second tick restores the patterns.
- d2=4'hB → slot 2 shows seg=FF and dig=4'b1011. No other slot is affected.
